// File: rtl/sram_controller.sv
// Memory-stage controller that splits each 32-bit load/store into two
// halfword accesses on a 16-bit asynchronous SRAM. It stalls the pipeline while it works.
module sram_controller #(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              freez,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        req;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - BASE_ADDR;
  // Byte-lane bits and bits above the SRAM's reach are dropped from the word index.
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    case (state_q)
      IDLE: begin
        if (req) begin
          word_d  = offset[ADDR_W:2];
          wdata_d = write_data;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO: begin
        sram_addr = {word_q, 1'b0};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == CNT_LAST) begin
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        sram_addr = {word_q, 1'b1};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == CNT_LAST) begin
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so a request held during reset cannot stall the pipeline.
  assign freez = reset & ((state_q == LO) | (state_q == HI) | ((state_q == IDLE) & req));

  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: a W=5 and a W=1 instance share one
// behavioural SRAM and are checked against a word-level reference model.
module tb_sram_controller;

  localparam int ADDR_W = 18;

  logic clock = 1'b0;
  logic reset;
  logic sel;
  logic rd_c, wr_c;
  logic [31:0] addr_c, wdata_c;

  logic [31:0] rdata0, rdata1;
  logic freez0, freez1, oe0, oe1, we0, we1;
  logic [ADDR_W-1:0] saddr0, saddr1;
  logic [15:0] dqo0, dqo1, dqi0, dqi1;

  logic [15:0] sram_mem [0:4095];
  logic [31:0] model_mem [0:2047];
  logic [31:0] last_read;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(5), .BASE_ADDR(32'd1024)) dut0 (
    .clock(clock), .reset(reset),
    .rd_en(rd_c & ~sel), .wr_en(wr_c & ~sel),
    .address(addr_c), .write_data(wdata_c),
    .read_data(rdata0), .freez(freez0),
    .sram_addr(saddr0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
    .sram_dq_in(dqi0), .sram_we_n(we0)
  );

  sram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clock(clock), .reset(reset),
    .rd_en(rd_c & sel), .wr_en(wr_c & sel),
    .address(addr_c), .write_data(wdata_c),
    .read_data(rdata1), .freez(freez1),
    .sram_addr(saddr1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
    .sram_dq_in(dqi1), .sram_we_n(we1)
  );

  assign dqi0 = sram_mem[saddr0[11:0]];
  assign dqi1 = sram_mem[saddr1[11:0]];

  always @(negedge clock) begin
    if (!we0) sram_mem[saddr0[11:0]] <= dqo0;
    if (!we1) sram_mem[saddr1[11:0]] <= dqo1;
  end

  wire              f_o    = sel ? freez1 : freez0;
  wire              we_o   = sel ? we1    : we0;
  wire              oe_o   = sel ? oe1    : oe0;
  wire [ADDR_W-1:0] addr_o = sel ? saddr1 : saddr0;
  wire [15:0]       dq_o   = sel ? dqo1   : dqo0;
  wire [31:0]       rd_o   = sel ? rdata1 : rdata0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge of DONE.
  task automatic run_access(input bit wr, input bit rd, input int word,
                            input logic [31:0] data, output int nf);
    int w, k, nwe, noe, nlo, nhi;
    bit done;
    logic [ADDR_W-1:0] a_lo, a_hi;
    logic [31:0] exp_rd;
    w = sel ? 1 : 5;
    a_lo = ADDR_W'(word * 2);
    a_hi = a_lo + 1'b1;
    addr_c  = 32'd1024 + 32'(word * 4) + 32'($urandom_range(0, 3));
    wr_c    = wr;
    rd_c    = rd;
    wdata_c = data;
    #1;
    check("start_freez", 32'(f_o), 32'd1);
    k = 0; nf = 0; nwe = 0; noe = 0; nlo = 0; nhi = 0; done = 0;
    while (k <= 4 * w + 10) begin
      if (f_o) nf++;
      else if (k > 0) begin done = 1; break; end
      if (!we_o) nwe++;
      if (oe_o) noe++;
      if (k >= 1 && k <= w && addr_o == a_lo && (!wr || dq_o == data[15:0])) nlo++;
      if (k > w && k <= 2 * w && addr_o == a_hi && (!wr || dq_o == data[31:16])) nhi++;
      @(negedge clock); #1;
      k++;
    end
    check("timeout", 32'(done), 32'd1);
    check("done_cycle", 32'(k), 32'(2 * w + 1));
    check("freez_len", 32'(nf), 32'(2 * w + 1));
    check("we_low", 32'(nwe), wr ? 32'(2 * w) : 32'd0);
    check("oe_high", 32'(noe), wr ? 32'(2 * w) : 32'd0);
    check("lo_phase", 32'(nlo), 32'(w));
    check("hi_phase", 32'(nhi), 32'(w));
    check("done_we_n", 32'(we_o), 32'd1);
    exp_rd = wr ? last_read : model_mem[word];
    check("read_data", rd_o, exp_rd);
    if (wr) begin
      model_mem[word] = data;
      check("sram_lo", 32'(sram_mem[a_lo[11:0]]), 32'(data[15:0]));
      check("sram_hi", 32'(sram_mem[a_hi[11:0]]), 32'(data[31:16]));
    end else begin
      last_read = model_mem[word];
    end
    $display("txn dut%0d %s word=%0d data=%h rdata=%h freez_cycles=%0d",
             sel, wr ? "WR" : "RD", word, data, rd_o, nf);
  endtask

  task automatic idle_cycles(input int n);
    rd_c = 0;
    wr_c = 0;
    repeat (n) begin
      @(negedge clock); #1;
      check("idle_freez", 32'(f_o), 32'd0);
    end
  endtask

  initial begin
    int nf1, nf2, word;
    bit wr, rd;
    logic [31:0] d;
    reset = 0; sel = 0; rd_c = 0; wr_c = 0; addr_c = 0; wdata_c = 0;
    last_read = 0;
    for (int i = 0; i < 4096; i++) sram_mem[i] = 16'h0;
    for (int i = 0; i < 2048; i++) model_mem[i] = 32'h0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_freez", 32'(f_o), 32'd0);
    check("rst_we_n", 32'(we_o), 32'd1);
    check("rst_oe", 32'(oe_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_dq", 32'(dq_o), 32'd0);
    check("rst_rdata", rd_o, 32'd0);
    reset = 1;
    idle_cycles(2);

    run_access(1, 0, 2, 32'hDEADBEEF, nf1);
    check("hw4", 32'(sram_mem[4]), 32'h0000BEEF);
    check("hw5", 32'(sram_mem[5]), 32'h0000DEAD);
    idle_cycles(2);
    run_access(0, 1, 2, 32'h0, nf1);
    check("read_1032", rd_o, 32'hDEADBEEF);
    check("read_done_freez", 32'(f_o), 32'd0);
    idle_cycles(1);

    run_access(1, 0, 3, 32'h0BADF00D, nf1);
    @(negedge clock); #1;
    run_access(0, 1, 3, 32'h0, nf2);
    check("b2b_total", 32'(nf1 + nf2), 32'd22);
    idle_cycles(2);

    run_access(1, 1, 5, 32'h12345678, nf1);
    check("both_rdata_kept", rd_o, 32'h0BADF00D);
    idle_cycles(2);

    addr_c = 32'd1024 + 32'd400; wdata_c = 32'hCAFEF00D; wr_c = 1;
    repeat (3) @(negedge clock);
    #1 reset = 0;
    #1;
    check("abort_freez", 32'(f_o), 32'd0);
    check("abort_we_n", 32'(we_o), 32'd1);
    check("abort_oe", 32'(oe_o), 32'd0);
    check("abort_addr", 32'(addr_o), 32'd0);
    check("abort_dq", 32'(dq_o), 32'd0);
    check("abort_rdata", rd_o, 32'd0);
    model_mem[100][15:0] = 16'hF00D;
    last_read = 0;
    check("abort_hw_lo", 32'(sram_mem[200]), 32'(model_mem[100][15:0]));
    check("abort_hw_hi", 32'(sram_mem[201]), 32'(model_mem[100][31:16]));
    wr_c = 0;
    @(negedge clock); #1 reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("post_rst_freez", 32'(f_o), 32'd0);
      check("post_rst_we_n", 32'(we_o), 32'd1);
    end
    run_access(0, 1, 100, 32'h0, nf1);
    idle_cycles(1);

    for (int i = 0; i < 24; i++) begin
      word = $urandom_range(0, 2047);
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 7) == 0);
      d = $urandom;
      run_access(wr, rd, word, d, nf1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clock); #1;
      end else begin
        idle_cycles($urandom_range(1, 3));
      end
    end
    idle_cycles(1);

    run_access(1, 0, 0, 32'hA5A55A5A, nf1);
    idle_cycles(1);
    sel = 1;
    idle_cycles(1);
    run_access(0, 1, 0, 32'h0, nf1);
    check("w1_read_1024", rd_o, 32'hA5A55A5A);
    idle_cycles(1);
    for (int i = 0; i < 8; i++) begin
      word = $urandom_range(0, 2047);
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      run_access(wr, !wr, word, d, nf1);
      idle_cycles(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
